// File: rtl/nv_ram_pkg.sv
// Shared types, constants and the byte-merge helper for the parametrised rws RAM.
package nv_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int BYTE_W = 8;

    // merge() works on a fixed maximum width; callers zero-extend and truncate to WIDTH.
    localparam int MAX_W = 2048;
    localparam int MAX_B = MAX_W / BYTE_W;

    function automatic logic [MAX_W-1:0] merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] mask
    );
        logic [MAX_W-1:0] res;
        for (int i = 0; i < MAX_B; i++) begin
            res[i*BYTE_W +: BYTE_W] = mask[i] ? new_w[i*BYTE_W +: BYTE_W] : old_w[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/nv_ram_rws_param_if.sv
// Read/write port bundle of the parametrised rws RAM; the RAM side uses the slave modport.
interface nv_ram_rws_param_if
    import nv_ram_pkg::*;
#(
    parameter int AW    = 6,
    parameter int WIDTH = 256
) ();

    logic [AW-1:0]           ra;
    logic                    re;
    logic [WIDTH-1:0]        dout;
    logic                    dout_vld;
    logic [AW-1:0]           wa;
    logic                    we;
    logic [WIDTH-1:0]        di;
    logic [WIDTH/BYTE_W-1:0] wmask;
    logic                    init_done;
    logic [31:0]             pwrbus_ram_pd;

    modport master (
        output ra, re, wa, we, di, wmask, pwrbus_ram_pd,
        input  dout, dout_vld, init_done
    );

    modport slave (
        input  ra, re, wa, we, di, wmask, pwrbus_ram_pd,
        output dout, dout_vld, init_done
    );

endinterface

// File: rtl/nv_ram_init_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in READY until the next reset.
module nv_ram_init_seq
    import nv_ram_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int AW        = 6,
    parameter int INIT_ZERO = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_we,
    output logic [AW-1:0] init_wa,
    output logic          init_done
);

    localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);

    ram_state_e    state_d, state_q;
    logic [AW-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_A) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ZERO != 0) ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_we   = (state_q == INIT);
    assign init_wa   = cnt_q;
    assign init_done = (state_q == READY);

endmodule

// File: rtl/nv_ram_rws_param.sv
// Parametrised registered-read simple dual-port RAM with byte masks, optional output
// register, selectable read-during-write forwarding and optional post-reset zero fill.
module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 256,
    parameter int AW        = $clog2(DEPTH),
    parameter int OUT_REG   = 0,
    parameter int WR_FWD    = 1,
    parameter int INIT_ZERO = 1
) (
    input logic               clk,
    input logic               rst,
    nv_ram_rws_param_if.slave bus
);

    localparam int          NB      = WIDTH / BYTE_W;
    localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

    logic             init_we;
    logic             init_done;
    logic [AW-1:0]    init_wa;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [NB-1:0]    wmask;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             user_we;
    logic             rd_fire;
    logic             fwd_hit;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] rd_word;

    logic             stg_vld;
    logic [WIDTH-1:0] stg_data;
    logic [WIDTH-1:0] dout_d, dout_q;
    logic             dout_vld_d, dout_vld_q;

    // The power-down bus is only carried for pin compatibility.
    logic unused_pwrbus;
    assign unused_pwrbus = ^bus.pwrbus_ram_pd;

    assign wmask = bus.wmask;

    nv_ram_init_seq #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_ZERO (INIT_ZERO)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_we   (init_we),
        .init_wa   (init_wa),
        .init_done (init_done)
    );

    // Addresses beyond DEPTH never touch the array: writes drop, reads return zero.
    always_comb begin
        wr_in_range = {1'b0, bus.wa} < DEPTH_A;
        rd_in_range = {1'b0, bus.ra} < DEPTH_A;
        user_we     = init_done && bus.we && wr_in_range;
        rd_fire     = init_done && bus.re;
        wr_old      = wr_in_range ? mem[bus.wa] : '0;
        wr_merged   = WIDTH'(merge(MAX_W'(wr_old), MAX_W'(bus.di), MAX_B'(wmask)));
        fwd_hit     = (WR_FWD != 0) && user_we && (bus.ra == bus.wa);
        rd_word     = rd_in_range ? mem[bus.ra] : '0;
        if (fwd_hit) begin
            rd_word = wr_merged;
        end
        mem_we = init_we || user_we;
        mem_wa = init_we ? init_wa : bus.wa;
        mem_wd = init_we ? '0 : wr_merged;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             s1_vld_d, s1_vld_q;
            logic [WIDTH-1:0] s1_data_d, s1_data_q;

            always_comb begin
                s1_vld_d  = rd_fire;
                s1_data_d = rd_fire ? rd_word : s1_data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q  <= s1_vld_d;
                    s1_data_q <= s1_data_d;
                end
            end

            assign stg_vld  = s1_vld_q;
            assign stg_data = s1_data_q;
        end else begin : g_no_out_reg
            assign stg_vld  = rd_fire;
            assign stg_data = rd_word;
        end
    endgenerate

    // dout only moves when a read completes, so later writes cannot leak into it.
    always_comb begin
        dout_vld_d = stg_vld;
        dout_d     = stg_vld ? stg_data : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.init_done = init_done;

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Drives two RAM instances (64 deep / latency 1 / forwarding, 48 deep / latency 2 / no forwarding)
// from one directed sequence and scores their read results against a behavioural model.
module tb_nv_ram_rws_param;

    typedef struct {
        logic [255:0] data;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [5:0]   ra;
    logic         re;
    logic [5:0]   wa;
    logic         we;
    logic [255:0] di;
    logic [31:0]  wmask;

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    logic         rst_at_edge = 1'b0;
    logic         rdy0, rdy1;
    logic         ev0, ev1;
    logic [255:0] exp_d0, exp_d1;
    logic [255:0] m0 [64];
    logic [255:0] m1 [64];
    exp_t         q0[$];
    exp_t         q1[$];

    nv_ram_rws_param_if #(.AW(6), .WIDTH(256)) bus0 ();
    nv_ram_rws_param_if #(.AW(6), .WIDTH(256)) bus1 ();

    assign bus0.ra = ra;  assign bus0.re = re;  assign bus0.wa = wa;  assign bus0.we = we;
    assign bus0.di = di;  assign bus0.wmask = wmask;  assign bus0.pwrbus_ram_pd = 32'h0;
    assign bus1.ra = ra;  assign bus1.re = re;  assign bus1.wa = wa;  assign bus1.we = we;
    assign bus1.di = di;  assign bus1.wmask = wmask;  assign bus1.pwrbus_ram_pd = 32'h0;

    nv_ram_rws_param #(
        .DEPTH(64), .WIDTH(256), .OUT_REG(0), .WR_FWD(1), .INIT_ZERO(1)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    nv_ram_rws_param #(
        .DEPTH(48), .WIDTH(256), .OUT_REG(1), .WR_FWD(0), .INIT_ZERO(1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    function automatic logic [255:0] bmerge(input logic [255:0] o, input logic [255:0] n, input logic [31:0] m);
        logic [255:0] r;
        for (int b = 0; b < 32; b++) begin
            r[b*8 +: 8] = m[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] pattern(input int a);
        return {32{8'hA5}} ^ 256'(a * 32'h0101_0101);
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; the model is updated only for instances the bench believes are ready.
    task automatic applyStimulus(input logic wr, input logic [5:0] waddr, input logic [255:0] wdata,
                                 input logic [31:0] mask, input logic rd, input logic [5:0] raddr);
        logic [255:0] e;
        @(negedge clk);
        we = wr; wa = waddr; di = wdata; wmask = mask; re = rd; ra = raddr;
        if (rdy0) begin
            if (rd) begin
                e = m0[raddr];
                if (wr && waddr == raddr) e = bmerge(m0[raddr], wdata, mask);
                q0.push_back('{data: e, due: cyc + 1});
            end
            if (wr) m0[waddr] = bmerge(m0[waddr], wdata, mask);
        end
        if (rdy1) begin
            if (rd) begin
                e = (raddr < 6'd48) ? m1[raddr] : '0;
                q1.push_back('{data: e, due: cyc + 2});
            end
            if (wr && waddr < 6'd48) m1[waddr] = bmerge(m1[waddr], wdata, mask);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, '0, '0, 1'b0, 6'd0);
    endtask

    // Scoreboard: every cycle each instance must show dout_vld exactly when a result is due,
    // and dout must equal the last delivered result (zero after reset).
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_at_edge) begin
                exp_d0 = '0; exp_d1 = '0;
                q0.delete(); q1.delete();
            end
            ev0 = (q0.size() != 0) && (q0[0].due == cyc);
            if (ev0) begin
                exp_d0 = q0[0].data;
                void'(q0.pop_front());
            end
            checkOutput("dut0_vld", 256'(bus0.dout_vld), 256'(ev0));
            checkOutput("dut0_dout", bus0.dout, exp_d0);
            ev1 = (q1.size() != 0) && (q1[0].due == cyc);
            if (ev1) begin
                exp_d1 = q1[0].data;
                void'(q1.pop_front());
            end
            checkOutput("dut1_vld", 256'(bus1.dout_vld), 256'(ev1));
            checkOutput("dut1_dout", bus1.dout, exp_d1);
        end
    end

    initial begin
        logic [255:0] xw, yw, d;
        logic [5:0]   wa_r, ra_r;

        rst = 1'b1; we = 1'b0; re = 1'b0; wa = '0; ra = '0; di = '0; wmask = '0;
        rdy0 = 1'b0; rdy1 = 1'b0; exp_d0 = '0; exp_d1 = '0;
        for (int i = 0; i < 64; i++) begin m0[i] = '0; m1[i] = '0; end

        $display("[TB] reset and zero-fill");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_init_done0", 256'(bus0.init_done), 256'(0));
        checkOutput("rst_init_done1", 256'(bus1.init_done), 256'(0));
        rst = 1'b0;
        for (int k = 0; k < 70; k++) begin
            applyStimulus(k >= 10 && k <= 12, 6'd3, '1, '1, k >= 10 && k <= 12, 6'd3);
            checkOutput("init_done0", 256'(bus0.init_done), 256'(k + 1 >= 64));
            checkOutput("init_done1", 256'(bus1.init_done), 256'(k + 1 >= 48));
        end
        rdy0 = 1'b1; rdy1 = 1'b1;

        $display("[TB] read-back after zero-fill");
        for (int a = 0; a < 64; a++) applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'(a));

        $display("[TB] pattern write and back-to-back reads");
        for (int a = 0; a < 64; a++) applyStimulus(1'b1, 6'(a), pattern(a), '1, 1'b0, 6'd0);
        for (int a = 0; a < 64; a++) applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'(a));

        $display("[TB] byte mask");
        applyStimulus(1'b1, 6'd5, '1, '1, 1'b0, 6'd0);
        applyStimulus(1'b1, 6'd5, '0, 32'h0000_000F, 1'b0, 6'd0);
        applyStimulus(1'b1, 6'd9, '1, 32'h0000_0000, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd5);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd9);

        $display("[TB] read during write");
        xw = {8{32'h1357_9BDF}};
        yw = {8{32'h2468_ACE0}};
        applyStimulus(1'b1, 6'd7, xw, '1, 1'b0, 6'd0);
        applyStimulus(1'b1, 6'd7, yw, '1, 1'b1, 6'd7);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd7);
        applyStimulus(1'b1, 6'd8, yw, 32'hF0F0_F0F0, 1'b1, 6'd8);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd8);

        $display("[TB] out-of-range access");
        applyStimulus(1'b1, 6'd50, {8{32'hDEAD_BEEF}}, '1, 1'b0, 6'd0);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd50);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd2);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd47);
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            wa_r = 6'($urandom_range(0, 63));
            ra_r = ($urandom_range(0, 3) == 0) ? wa_r : 6'($urandom_range(0, 63));
            d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(1'($urandom_range(0, 1)), wa_r, d, $urandom(), 1'($urandom_range(0, 1)), ra_r);
        end
        idle(4);

        $display("[TB] reset during zero-fill");
        @(negedge clk);
        rst = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(19);
        applyStimulus(1'b1, 6'd4, '1, '1, 1'b1, 6'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 70; k++) begin
            applyStimulus(k == 30, 6'd6, '1, '1, k == 30, 6'd6);
            checkOutput("reinit_done0", 256'(bus0.init_done), 256'(k + 1 >= 64));
            checkOutput("reinit_done1", 256'(bus1.init_done), 256'(k + 1 >= 48));
        end
        for (int i = 0; i < 64; i++) begin m0[i] = '0; m1[i] = '0; end
        rdy0 = 1'b1; rdy1 = 1'b1;
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd4);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd6);
        applyStimulus(1'b0, 6'd0, '0, '0, 1'b1, 6'd63);
        idle(4);

        checkOutput("q0_drained", 256'(q0.size()), 256'(0));
        checkOutput("q1_drained", 256'(q1.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
